encoder_8_3_pend: RTL and testbench

//  Registered 8-to-3 priority encoder with pending-request latch and valid/ack handshake.

---
 rtl/encoder_8_3_pend.sv | 125 ++++++++++++
 tb/tb_encoder_8_3_pend.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_8_3_pend.sv
// encoder_8_3_pend: registered 8-to-3 priority encoder with a pending-request
// latch and a valid/ack handshake toward the consumer (which feeds Out back
// into decoder_3_8).
// Optional feature macro: ROUND_ROBIN_EN (rotating search start, no starvation).
// Without it, selection is fixed priority with the highest index winning.
module encoder_8_3_pend #(
  parameter bit EDGE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic [7:0] In,
  input  logic       ack,
  output logic [2:0] Out,
  output logic       valid,
  output logic [7:0] pend
);

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state, state_n;
  logic [N-1:0]   in_d;
  logic [N-1:0]   capture;
  logic [N-1:0]   clear;
  logic [N-1:0]   pend_n;
  logic [W-1:0]   out_n;
  logic           valid_n;
  logic [W-1:0]   sel;
`ifdef ROUND_ROBIN_EN
  logic [W-1:0]   last, last_n;
  logic [W-1:0]   idx;
`endif

  // New requests: level or rising-edge, gated by the enable pin
  always_comb begin
    capture = '0;
    if (E) capture = EDGE ? (In & ~in_d) : In;
  end

  // Bit to retire when the consumer accepts the current grant
  always_comb begin
    clear = '0;
    if (valid && ack) clear = N'(1) << Out;
  end

`ifdef ROUND_ROBIN_EN
  // Rotating search: start just below the last granted index, wrap 0 -> 7
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'(last - W'(1) - W'(i));
      if (pend[idx]) sel = idx;
    end
  end
`else
  // Fixed priority: highest set index wins
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) sel = W'(i);
    end
  end
`endif

  // Next-state and next-output logic; set wins over clear on the same bit
  always_comb begin
    state_n = state;
    out_n   = Out;
    valid_n = valid;
    pend_n  = (pend & ~clear) | capture;
`ifdef ROUND_ROBIN_EN
    last_n  = last;
`endif
    case (state)
      IDLE: begin
        if (pend != '0) begin
          out_n   = sel;
          valid_n = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          valid_n = 1'b0;
`ifdef ROUND_ROBIN_EN
          last_n  = Out;
`endif
          state_n = IDLE;
        end
      end
      default: begin
        valid_n = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any grant in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      Out   <= '0;
      valid <= 1'b0;
      pend  <= '0;
      in_d  <= '0;
`ifdef ROUND_ROBIN_EN
      last  <= '0;
`endif
    end else begin
      state <= state_n;
      Out   <= out_n;
      valid <= valid_n;
      pend  <= pend_n;
      in_d  <= In;
`ifdef ROUND_ROBIN_EN
      last  <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_encoder_8_3_pend.sv
// Directed bench for encoder_8_3_pend: u0 runs level capture, u1 edge capture,
// both driven by the same inputs.
module tb_encoder_8_3_pend;

  logic       clk = 1'b0;
  logic       rst;
  logic       E;
  logic [7:0] In;
  logic       ack;
  logic [2:0] out0, out1;
  logic       valid0, valid1;
  logic [7:0] pend0, pend1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  encoder_8_3_pend #(.EDGE(1'b0)) u0 (
    .clk(clk), .rst(rst), .E(E), .In(In), .ack(ack),
    .Out(out0), .valid(valid0), .pend(pend0)
  );

  encoder_8_3_pend #(.EDGE(1'b1)) u1 (
    .clk(clk), .rst(rst), .E(E), .In(In), .ack(ack),
    .Out(out1), .valid(valid1), .pend(pend1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    E = 1'b1; In = 8'h20; ack = 1'b0;
    step();
    In = 8'h00;
    step();
    total++;
    if (valid0 !== 1'b1 || out0 !== 3'd5) begin
      bad++; $display("FAIL reset_pre: valid=%b out=%0d want valid=1 out=5", valid0, out0);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (valid0 !== 1'b0 || out0 !== 3'd0 || pend0 !== 8'h00) begin
      bad++; $display("FAIL reset_async: valid=%b out=%0d pend=%h want 0/0/00", valid0, out0, pend0);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (valid0 !== 1'b0 || pend0 !== 8'h00) begin
        bad++; $display("FAIL reset_idle: valid=%b pend=%h want 0/00", valid0, pend0);
      end
    end
  endtask

  task automatic test_single();
    E = 1'b1; ack = 1'b0; In = 8'h10;
    step();
    In = 8'h00;
    total++;
    if (pend0 !== 8'h10 || valid0 !== 1'b0) begin
      bad++; $display("FAIL single_pend: pend=%h valid=%b want 10/0", pend0, valid0);
    end
    step();
    total++;
    if (valid0 !== 1'b1 || out0 !== 3'd4) begin
      bad++; $display("FAIL single_grant: valid=%b out=%0d want 1/4", valid0, out0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (valid0 !== 1'b1 || out0 !== 3'd4 || pend0 !== 8'h10) begin
        bad++; $display("FAIL single_hold: valid=%b out=%0d pend=%h want 1/4/10", valid0, out0, pend0);
      end
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    total++;
    if (valid0 !== 1'b0 || pend0 !== 8'h00) begin
      bad++; $display("FAIL single_ack: valid=%b pend=%h want 0/00", valid0, pend0);
    end
  endtask

  task automatic test_priority();
    E = 1'b1; ack = 1'b1; In = 8'h81;
    step();
    In = 8'h00;
    total++;
    if (pend1 !== 8'h81) begin
      bad++; $display("FAIL prio_pend: pend=%h want 81", pend1);
    end
    step();
    total++;
    if (valid1 !== 1'b1 || out1 !== 3'd7) begin
      bad++; $display("FAIL prio_first: valid=%b out=%0d want 1/7", valid1, out1);
    end
    step();
    total++;
    if (valid1 !== 1'b0 || pend1 !== 8'h01) begin
      bad++; $display("FAIL prio_gap: valid=%b pend=%h want 0/01", valid1, pend1);
    end
    step();
    total++;
    if (valid1 !== 1'b1 || out1 !== 3'd0) begin
      bad++; $display("FAIL prio_second: valid=%b out=%0d want 1/0", valid1, out1);
    end
    step();
    total++;
    if (valid1 !== 1'b0 || pend1 !== 8'h00) begin
      bad++; $display("FAIL prio_final: valid=%b pend=%h want 0/00", valid1, pend1);
    end
    ack = 1'b0;
  endtask

  task automatic test_enable();
    E = 1'b0; ack = 1'b0; In = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (pend0 !== 8'h00 || valid0 !== 1'b0 || pend1 !== 8'h00 || valid1 !== 1'b0) begin
        bad++; $display("FAIL enable_block: pend0=%h v0=%b pend1=%h v1=%b want 00/0", pend0, valid0, pend1, valid1);
      end
    end
    In = 8'h00;
    step();
    E = 1'b1;
    step();
  endtask

  task automatic test_set_over_clear();
    E = 1'b1; ack = 1'b0; In = 8'h04;
    step();
    In = 8'h00;
    step();
    total++;
    if (valid1 !== 1'b1 || out1 !== 3'd2) begin
      bad++; $display("FAIL soc_grant: valid=%b out=%0d want 1/2", valid1, out1);
    end
    ack = 1'b1; In = 8'h04;
    step();
    ack = 1'b0; In = 8'h00;
    total++;
    if (pend1 !== 8'h04 || valid1 !== 1'b0) begin
      bad++; $display("FAIL soc_pend: pend=%h valid=%b want 04/0", pend1, valid1);
    end
    step();
    total++;
    if (valid1 !== 1'b1 || out1 !== 3'd2) begin
      bad++; $display("FAIL soc_regrant: valid=%b out=%0d want 1/2", valid1, out1);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic test_fairness();
    logic [2:0] exp [4];
    int got;
    int cyc;
`ifdef ROUND_ROBIN_EN
    exp = '{3'd7, 3'd0, 3'd7, 3'd0};
`else
    exp = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
    In = 8'h00; ack = 1'b0; E = 1'b1;
    do_reset();
    In = 8'h81; ack = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 40) begin
      step();
      cyc++;
      if (valid0) begin
        total++;
        if (out0 !== exp[got]) begin
          bad++; $display("FAIL fair_grant%0d: out=%0d want %0d", got, out0, exp[got]);
        end
        got++;
      end
    end
    total++;
    if (got != 4) begin
      bad++; $display("FAIL fair_timeout: grants=%0d want 4", got);
    end
    In = 8'h00; ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; E = 1'b0; In = 8'h00; ack = 1'b0;
    step();
    rst = 1'b0;
    step();
    total++;
    if (valid0 !== 1'b0 || out0 !== 3'd0 || pend0 !== 8'h00) begin
      bad++; $display("FAIL init: valid=%b out=%0d pend=%h want 0/0/00", valid0, out0, pend0);
    end
    test_reset();
    test_single();
    test_priority();
    test_enable();
    test_set_over_clear();
    test_fairness();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
